// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch/load-use hazard stall and flush sequencer with perf counters
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Hold,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_Branch,
    input  logic             ID_Jump,
    input  logic             ID_BranchTaken,
    input  logic [4:0]       EX_Rw,
    input  logic [4:0]       MEM_Rw,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic             CntClear,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;

    logic ex_rs_hit;
    logic ex_rt_hit;
    logic mem_rs_hit;
    logic mem_rt_hit;
    logic need2;
    logic need1;
    logic stall;

    // Producer matches: nonzero destination, equal to the source, and actually being written
    always_comb begin
        ex_rs_hit  = (ID_rs != 5'd0) && (ID_rs == EX_Rw)  && EX_RegWrite;
        ex_rt_hit  = (ID_rt != 5'd0) && (ID_rt == EX_Rw)  && EX_RegWrite;
        mem_rs_hit = (ID_rs != 5'd0) && (ID_rs == MEM_Rw) && MEM_RegWrite;
        mem_rt_hit = (ID_rt != 5'd0) && (ID_rt == MEM_Rw) && MEM_RegWrite;

        // Branch needing a load still in EX must wait two cycles for the value to reach WB
        need2 = ID_Branch && (ex_rs_hit || ex_rt_hit) && EX_MemRead;

        // One-cycle cases: ALU result in EX for a branch, load in MEM for a branch,
        // or a classic load-use for any instruction reading the loaded register
        need1 = (ID_Branch && (ex_rs_hit || ex_rt_hit) && !EX_MemRead)
             || (ID_Branch && (mem_rs_hit || mem_rt_hit) && MEM_MemRead)
             || (((ID_UseRs && ex_rs_hit) || (ID_UseRt && ex_rt_hit)) && EX_MemRead);

        // In STALL the hazard inputs are stale, so the FSM alone holds the stall
        stall = (state == S_STALL) || need2 || need1;
    end

    // State register and remaining-stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: only the two-cycle hazard enters STALL; Hold freezes everything
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!Hold) begin
            case (state)
                S_RUN: begin
                    if (need2) begin
                        state_nx = S_STALL;
                        cnt_nx   = 2'd1;
                    end
                end
                S_STALL: begin
                    cnt_nx = cnt - 2'd1;
                    if (cnt_nx == 2'd0) begin
                        state_nx = S_RUN;
                    end
                end
                default: begin
                    state_nx = S_RUN;
                    cnt_nx   = 2'd0;
                end
            endcase
        end
    end

    // Pipeline control outputs: reset forcing first, then Hold, then stall/flush
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        if (reset) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (Hold) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
        end else begin
            PC_Write     = !stall;
            IF_ID_Write  = !stall;
            ID_EX_Bubble = stall;
            // A stalled branch has unresolved operands, so it never flushes
            IF_ID_Flush  = !stall && (ID_Jump || (ID_Branch && ID_BranchTaken));
        end
    end

    // Saturating performance counters; clear takes priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else if (CntClear) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (stall && !Hold && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_ONE;
            end
            if (IF_ID_Flush && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - table-driven and sequence checks for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             Hold;
    logic [4:0]       ID_rs, ID_rt;
    logic             ID_UseRs, ID_UseRt, ID_Branch, ID_Jump, ID_BranchTaken;
    logic [4:0]       EX_Rw, MEM_Rw;
    logic             EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
    logic             CntClear;
    logic             PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic [CNT_W-1:0] StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       hold;
        logic       br;
        logic       jmp;
        logic       taken;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex_rw;
        logic       ex_we;
        logic       ex_mr;
        logic [4:0] mem_rw;
        logic       mem_we;
        logic       mem_mr;
        logic       e_pc;
        logic       e_ifid;
        logic       e_bub;
        logic       e_flush;
    } vec_t;

    vec_t vecs[14];

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .Hold           (Hold),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .ID_UseRs       (ID_UseRs),
        .ID_UseRt       (ID_UseRt),
        .ID_Branch      (ID_Branch),
        .ID_Jump        (ID_Jump),
        .ID_BranchTaken (ID_BranchTaken),
        .EX_Rw          (EX_Rw),
        .MEM_Rw         (MEM_Rw),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .MEM_RegWrite   (MEM_RegWrite),
        .MEM_MemRead    (MEM_MemRead),
        .CntClear       (CntClear),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .IF_ID_Flush    (IF_ID_Flush),
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(
        input logic hold, input logic br, input logic jmp, input logic taken,
        input logic use_rs, input logic use_rt, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] ex_rw, input logic ex_we, input logic ex_mr,
        input logic [4:0] mem_rw, input logic mem_we, input logic mem_mr,
        input logic e_pc, input logic e_ifid, input logic e_bub, input logic e_flush);
        vec_t v;
        v.hold = hold; v.br = br; v.jmp = jmp; v.taken = taken;
        v.use_rs = use_rs; v.use_rt = use_rt; v.rs = rs; v.rt = rt;
        v.ex_rw = ex_rw; v.ex_we = ex_we; v.ex_mr = ex_mr;
        v.mem_rw = mem_rw; v.mem_we = mem_we; v.mem_mr = mem_mr;
        v.e_pc = e_pc; v.e_ifid = e_ifid; v.e_bub = e_bub; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic pc, input logic ifid,
                             input logic bub, input logic flush);
        check({name, ".PC_Write"},     32'(PC_Write),     32'(pc));
        check({name, ".IF_ID_Write"},  32'(IF_ID_Write),  32'(ifid));
        check({name, ".ID_EX_Bubble"}, 32'(ID_EX_Bubble), 32'(bub));
        check({name, ".IF_ID_Flush"},  32'(IF_ID_Flush),  32'(flush));
    endtask

    task automatic apply(input vec_t v);
        Hold = v.hold; ID_Branch = v.br; ID_Jump = v.jmp; ID_BranchTaken = v.taken;
        ID_UseRs = v.use_rs; ID_UseRt = v.use_rt; ID_rs = v.rs; ID_rt = v.rt;
        EX_Rw = v.ex_rw; EX_RegWrite = v.ex_we; EX_MemRead = v.ex_mr;
        MEM_Rw = v.mem_rw; MEM_RegWrite = v.mem_we; MEM_MemRead = v.mem_mr;
    endtask

    task automatic set_idle();
        apply(mkv(0,0,0,0, 0,0,5'd0,5'd0, 5'd0,0,0, 5'd0,0,0, 1,1,0,0));
        CntClear = 1'b0;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear counters with idle inputs for one cycle
    task automatic clear_counters();
        set_idle();
        CntClear = 1'b1;
        step();
        CntClear = 1'b0;
    endtask

    initial begin
        //             hold br jmp tk urs urt rs    rt     exrw  we mr memrw we mr  pc if bub fl
        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0); // idle
        vecs[1]  = mkv(0, 1, 0, 1, 1, 1, 5'd5, 5'd0, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0, 1, 0); // ALU->branch, taken
        vecs[2]  = mkv(0, 1, 0, 1, 1, 1, 5'd5, 5'd0, 5'd6, 1, 0, 5'd0, 0, 0, 1, 1, 0, 1); // taken, no hazard
        vecs[3]  = mkv(0, 0, 0, 0, 1, 1, 5'd3, 5'd4, 5'd3, 1, 1, 5'd0, 0, 0, 0, 0, 1, 0); // load-use rs
        vecs[4]  = mkv(0, 0, 0, 0, 1, 1, 5'd0, 5'd4, 5'd0, 1, 1, 5'd0, 0, 0, 1, 1, 0, 0); // $0 never matches
        vecs[5]  = mkv(0, 1, 0, 0, 1, 1, 5'd7, 5'd2, 5'd0, 0, 0, 5'd7, 1, 1, 0, 0, 1, 0); // load in MEM->branch
        vecs[6]  = mkv(0, 1, 0, 1, 1, 1, 5'd7, 5'd2, 5'd0, 0, 0, 5'd7, 1, 0, 1, 1, 0, 1); // ALU in MEM forwarded
        vecs[7]  = mkv(0, 1, 0, 0, 1, 1, 5'd9, 5'd2, 5'd9, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0); // EX RegWrite=0
        vecs[8]  = mkv(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 1); // jump
        vecs[9]  = mkv(1, 1, 0, 1, 1, 1, 5'd5, 5'd0, 5'd5, 1, 0, 5'd0, 0, 0, 0, 0, 0, 0); // hold over hazard
        vecs[10] = mkv(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0); // hold over jump
        vecs[11] = mkv(0, 0, 0, 0, 1, 1, 5'd1, 5'd12,5'd12,1, 0, 5'd0, 0, 0, 1, 1, 0, 0); // ALU in EX, non-branch
        vecs[12] = mkv(0, 0, 0, 0, 0, 0, 5'd3, 5'd4, 5'd3, 1, 1, 5'd0, 0, 0, 1, 1, 0, 0); // load but rs unused
        vecs[13] = mkv(0, 0, 0, 0, 0, 1, 5'd1, 5'd14,5'd14,1, 1, 5'd0, 0, 0, 0, 0, 1, 0); // load-use rt

        set_idle();
        reset = 1'b1;
        #3;
        check_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset.StallCycles", 32'(StallCycles), 32'd0);
        check("reset.FlushCount",  32'(FlushCount),  32'd0);
        step();
        reset = 1'b0;
        #3;
        check_out("post_reset", 1'b1, 1'b1, 0, 0);

        // Table vectors: none of them enters STALL, so each is independent
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            #3;
            check_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifid, vecs[i].e_bub, vecs[i].e_flush);
            step();
        end

        // Load-to-branch, taken: two stall cycles, then flush on resolution
        clear_counters();
        apply(mkv(0,1,0,1, 1,1,5'd8,5'd9, 5'd8,1,1, 5'd0,0,0, 0,0,1,0));
        #3; check_out("ldbr.c1", 0, 0, 1, 0);
        step();
        // Load now in MEM: these inputs must be ignored while in STALL
        apply(mkv(0,1,0,1, 1,1,5'd8,5'd9, 5'd0,0,0, 5'd8,1,1, 0,0,1,0));
        #3; check_out("ldbr.c2", 0, 0, 1, 0);
        step();
        apply(mkv(0,1,0,1, 1,1,5'd8,5'd9, 5'd0,0,0, 5'd0,0,0, 1,1,0,1));
        #3; check_out("ldbr.c3", 1, 1, 0, 1);
        step();
        set_idle();
        #3;
        check("ldbr.StallCycles", 32'(StallCycles), 32'd2);
        check("ldbr.FlushCount",  32'(FlushCount),  32'd1);

        // ALU-to-branch, taken: one stall, then flush
        clear_counters();
        apply(mkv(0,1,0,1, 1,1,5'd5,5'd0, 5'd5,1,0, 5'd0,0,0, 0,0,1,0));
        #3; check_out("alubr.c1", 0, 0, 1, 0);
        step();
        apply(mkv(0,1,0,1, 1,1,5'd5,5'd0, 5'd0,0,0, 5'd5,1,0, 1,1,0,1));
        #3; check_out("alubr.c2", 1, 1, 0, 1);
        step();
        set_idle();
        #3;
        check("alubr.StallCycles", 32'(StallCycles), 32'd1);
        check("alubr.FlushCount",  32'(FlushCount),  32'd1);

        // Hold for three cycles inside a two-cycle stall
        clear_counters();
        apply(mkv(0,1,0,0, 1,1,5'd8,5'd9, 5'd8,1,1, 5'd0,0,0, 0,0,1,0));
        #3; check_out("hold.c1", 0, 0, 1, 0);
        step();
        apply(mkv(0,1,0,0, 1,1,5'd8,5'd9, 5'd0,0,0, 5'd8,1,1, 0,0,1,0));
        Hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            #3; check_out($sformatf("hold.h%0d", h), 0, 0, 0, 0);
            step();
        end
        Hold = 1'b0;
        #3; check_out("hold.c2", 0, 0, 1, 0);
        step();
        apply(mkv(0,1,0,0, 1,1,5'd8,5'd9, 5'd0,0,0, 5'd0,0,0, 1,1,0,0));
        #3; check_out("hold.c3", 1, 1, 0, 0);
        check("hold.StallCycles", 32'(StallCycles), 32'd2);
        step();

        // Reset asserted while in STALL
        clear_counters();
        apply(mkv(0,1,0,0, 1,1,5'd8,5'd9, 5'd8,1,1, 5'd0,0,0, 0,0,1,0));
        step();
        set_idle();
        #2;
        reset = 1'b1;
        #1;
        check_out("rststall", 0, 0, 1, 0);
        check("rststall.StallCycles", 32'(StallCycles), 32'd0);
        step();
        reset = 1'b0;
        #3;
        check_out("rststall.after", 1, 1, 0, 0);
        step();

        // Saturation at 2^CNT_W-1, then clear beats a simultaneous increment
        clear_counters();
        apply(mkv(0,0,0,0, 1,1,5'd3,5'd4, 5'd3,1,1, 5'd0,0,0, 0,0,1,0));
        for (int s = 0; s < 20; s++) step();
        check("sat.StallCycles", 32'(StallCycles), 32'd15);
        CntClear = 1'b1;
        #3; check("sat.stall_during_clear", 32'(ID_EX_Bubble), 32'd1);
        step();
        CntClear = 1'b0;
        check("sat.cleared", 32'(StallCycles), 32'd0);
        step();
        check("sat.recount", 32'(StallCycles), 32'd1);

        // Flush counter saturation with repeated jumps
        clear_counters();
        apply(mkv(0,0,1,0, 0,0,5'd0,5'd0, 5'd0,0,0, 5'd0,0,0, 1,1,0,1));
        for (int f = 0; f < 18; f++) step();
        check("flsat.FlushCount", 32'(FlushCount), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
